if_prefetch_stage: RTL and testbench

// Instruction-fetch stage: producer side of the {PC, Instruction} interface consumed by the IF/ID register and ID stage.

---
 rtl/arm_pkg.sv | 24 ++
 rtl/if_prefetch_fifo.sv | 68 ++++++
 rtl/if_prefetch_stage.sv | 171 +++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the instruction-fetch slice: word width, PC step,
// fetch FSM states and the prefetch FIFO entry layout.
package arm_pkg;

  localparam int          WORD_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] instr;
  } fifo_entry_t;

  // Sequential fetch address; wraps modulo 2^32 without any flag.
  function automatic logic [WORD_W-1:0] pc_advance(input logic [WORD_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO of {pc4, instr} entries. Flush wins over push and pop;
// push into a full FIFO and pop from an empty one are ignored.
module if_prefetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fifo_entry_t            push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output fifo_entry_t            head,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify the requests against the current occupancy.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
  end

  // Pointer and occupancy state; ptr arithmetic wraps because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (do_push_s && !rst && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Status flags and head view.
  always_comb begin
    count = count_r;
    head  = mem_r[rd_ptr_r];
    empty = (count_r == CNT_W'(0));
    full  = (count_r == CNT_W'(DEPTH));
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: keeps fetch_pc, runs the req/ack fetch FSM,
// buffers returned words and presents the FIFO head to IF/ID.
module if_prefetch_stage
  import arm_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] Instruction
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [WORD_W-1:0] fetch_pc_r;
  logic [WORD_W-1:0] fetch_pc_nxt_s;
  logic [WORD_W-1:0] stale_addr_r;
  logic [WORD_W-1:0] stale_addr_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  count_post_s;
  fifo_entry_t       head_s;
  fifo_entry_t       push_data_s;
  logic              empty_s;
  logic              full_s;

  if_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .count     (count_s),
    .head      (head_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  // State, fetch address and the address of a transfer being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      fetch_pc_r   <= RESET_PC;
      stale_addr_r <= RESET_PC;
    end else begin
      state_r      <= state_nxt_s;
      fetch_pc_r   <= fetch_pc_nxt_s;
      stale_addr_r <= stale_addr_nxt_s;
    end
  end

  // Next-state, push decision and fetch_pc update; a branch beats push and freeze.
  always_comb begin
    state_nxt_s      = state_r;
    fetch_pc_nxt_s   = fetch_pc_r;
    stale_addr_nxt_s = stale_addr_r;
    push_s           = 1'b0;
    push_data_s      = '{pc4: pc_advance(fetch_pc_r), instr: imem_rdata};
    count_post_s     = count_s - CNT_W'(pop_s);
    case (state_r)
      FETCH: begin
        if (branch_taken) begin
          fetch_pc_nxt_s = branch_addr;
          if (imem_ack) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s      = DRAIN;
            stale_addr_nxt_s = fetch_pc_r;
          end
        end else if (imem_ack) begin
          push_s         = 1'b1;
          fetch_pc_nxt_s = pc_advance(fetch_pc_r);
          if ((count_post_s + CNT_W'(1)) < CNT_W'(DEPTH)) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = FETCH;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          fetch_pc_nxt_s = branch_addr;
          state_nxt_s    = FETCH;
        end else if (full_s && !pop_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DRAIN: begin
        // The stale transfer must still complete; its data is never pushed.
        if (branch_taken) begin
          fetch_pc_nxt_s = branch_addr;
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        if (imem_ack) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // Memory request and IF/ID view of the FIFO head, all forced idle under reset.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = fetch_pc_r;
    if_valid    = 1'b0;
    PC          = 32'h0;
    Instruction = 32'h0;
    if (rst) begin
      imem_req = 1'b0;
      if_valid = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          imem_req  = 1'b1;
          imem_addr = fetch_pc_r;
        end
        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = stale_addr_r;
        end
        HOLD: begin
          imem_req  = 1'b0;
          imem_addr = fetch_pc_r;
        end
        default: begin
          imem_req  = 1'b0;
          imem_addr = fetch_pc_r;
        end
      endcase
      if (empty_s) begin
        if_valid = 1'b0;
      end else begin
        if_valid    = 1'b1;
        PC          = head_s.pc4;
        Instruction = head_s.instr;
      end
    end
  end

  // Head is consumed whenever it is presented and the pipeline is not frozen.
  always_comb begin
    pop_s = if_valid & ~freeze;
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: directed vector table, hand
// sequences for drain/long-wait corners, and a randomized stream-model run.
module tb_if_prefetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] PC;
  logic [31:0] Instruction;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .PC           (PC),
    .Instruction  (Instruction)
  );

  // Contents of instruction memory as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        frz;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                     input logic a, input logic ereq, input logic [31:0] eaddr,
                     input logic ev, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.baddr = ba; v.ack = a;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev; v.epc = epc;
    vecs.push_back(v);
  endtask

  // One cycle: drive after the edge (rdata follows the presented address), settle at negedge.
  task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] ba, input logic a);
    @(posedge clk);
    #1;
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_ack = a;
    imem_rdata = mem_word(imem_addr);
    @(negedge clk);
  endtask

  logic        pending;
  int          lat;
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] exp_pc4;
  int          idle;
  int          max_idle;
  int          pops;

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // rst frz br baddr ack | req addr valid pc
    add(1,0,0,32'h0,0,          0,32'h0,0,32'h0);
    add(1,0,0,32'h0,0,          0,32'h0,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h0,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h4,1,32'h4);
    add(0,0,0,32'h0,1,          1,32'h8,1,32'h8);
    add(0,0,0,32'h0,1,          1,32'hC,1,32'hC);
    add(0,1,0,32'h0,1,          1,32'h10,1,32'h10);
    for (int k = 0; k < 4; k++) add(0,1,0,32'h0,0, 0,32'h0,1,32'h10);
    add(0,0,0,32'h0,0,          0,32'h0,1,32'h10);
    add(0,0,0,32'h0,1,          1,32'h14,1,32'h14);
    add(0,0,0,32'h0,0,          1,32'h18,1,32'h18);
    add(0,0,0,32'h0,0,          1,32'h18,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h18,0,32'h0);
    add(0,0,0,32'h0,0,          1,32'h1C,1,32'h1C);
    add(0,0,0,32'h0,0,          1,32'h1C,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h1C,0,32'h0);
    add(0,0,1,32'h100,0,        1,32'h20,1,32'h20);
    add(0,0,0,32'h0,0,          1,32'h20,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h20,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h100,0,32'h0);
    add(0,0,0,32'h0,0,          1,32'h104,1,32'h104);
    add(0,0,1,32'h200,1,        1,32'h104,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h200,0,32'h0);
    add(0,0,0,32'h0,0,          1,32'h204,1,32'h204);
    add(1,0,0,32'h0,0,          0,32'h0,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'h0,0,32'h0);
    add(0,0,1,32'hFFFF_FFF8,0,  1,32'h4,1,32'h4);
    add(1,0,0,32'h0,0,          0,32'h0,0,32'h0);
    add(0,0,0,32'h0,0,          1,32'h0,0,32'h0);
    add(0,0,1,32'hFFFF_FFFC,1,  1,32'h0,0,32'h0);
    add(0,0,0,32'h0,1,          1,32'hFFFF_FFFC,0,32'h0);
    add(0,1,0,32'h0,0,          1,32'h0,1,32'h0);
    add(0,1,0,32'h0,0,          1,32'h0,1,32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; freeze = vecs[i].frz; branch_taken = vecs[i].br;
      branch_addr = vecs[i].baddr; imem_ack = vecs[i].ack;
      imem_rdata = mem_word(vecs[i].eaddr);
      @(negedge clk);
      check($sformatf("v%0d req", i), 32'(imem_req), 32'(vecs[i].ereq));
      if (vecs[i].ereq) check($sformatf("v%0d addr", i), imem_addr, vecs[i].eaddr);
      check($sformatf("v%0d valid", i), 32'(if_valid), 32'(vecs[i].evalid));
      check($sformatf("v%0d pc", i), PC, vecs[i].epc);
      check($sformatf("v%0d instr", i), Instruction,
            vecs[i].evalid ? mem_word(vecs[i].epc - 32'd4) : 32'h0);
    end

    // Long wait under freeze with an empty FIFO: request held, nothing presented.
    cyc(1,0,0,32'h0,0);
    for (int k = 0; k < 12; k++) begin
      cyc(0,1,0,32'h0,0);
      check("wait req", 32'(imem_req), 32'd1);
      check("wait addr", imem_addr, 32'h0);
      check("wait valid", 32'(if_valid), 32'd0);
    end
    cyc(0,1,0,32'h0,1);
    cyc(0,0,0,32'h0,0);
    check("wait pc", PC, 32'h4);
    check("wait instr", Instruction, mem_word(32'h0));
    check("wait next addr", imem_addr, 32'h4);

    // Second branch while draining keeps the stale address and retargets.
    cyc(0,0,1,32'h40,0);
    cyc(0,0,1,32'h80,0);
    check("drain2 addr", imem_addr, 32'h4);
    check("drain2 valid", 32'(if_valid), 32'd0);
    cyc(0,0,0,32'h0,0);
    check("drain3 addr", imem_addr, 32'h4);
    cyc(0,0,0,32'h0,1);
    cyc(0,0,0,32'h0,1);
    check("retarget addr", imem_addr, 32'h80);
    cyc(0,0,0,32'h0,0);
    check("retarget pc", PC, 32'h84);
    check("retarget instr", Instruction, mem_word(32'h80));

    // Randomized run against a stream model: presented words follow the program order.
    cyc(1,0,0,32'h0,0);
    cyc(1,0,0,32'h0,0);
    pending = 1'b0; lat = 0; prev_wait = 1'b0; prev_addr = 32'h0;
    exp_pc4 = RESET_PC + 32'd4; idle = 0; max_idle = 0; pops = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (imem_req) begin
        if (!pending) begin
          pending = 1'b1;
          lat = $urandom_range(0, 3);
        end
        if (lat == 0) begin
          imem_ack = 1'b1;
          pending  = 1'b0;
        end else begin
          imem_ack = 1'b0;
          lat--;
        end
      end else begin
        imem_ack = 1'b0;
      end
      imem_rdata   = mem_word(imem_addr);
      freeze       = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_addr  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) branch_addr = 32'hFFFF_FFF0 | (branch_addr & 32'hC);
      @(negedge clk);
      if (prev_wait) begin
        check("rnd req held", 32'(imem_req), 32'd1);
        check("rnd addr stable", imem_addr, prev_addr);
      end
      if (if_valid) begin
        check("rnd pc", PC, exp_pc4);
        check("rnd instr", Instruction, mem_word(exp_pc4 - 32'd4));
      end else begin
        check("rnd idle pc", PC, 32'h0);
        check("rnd idle instr", Instruction, 32'h0);
      end
      if (!if_valid && !branch_taken) idle++;
      else idle = 0;
      if (idle > max_idle) max_idle = idle;
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (branch_taken) begin
        exp_pc4 = branch_addr + 32'd4;
      end else if (if_valid && !freeze) begin
        exp_pc4 = exp_pc4 + 32'd4;
        pops++;
      end
    end
    check("rnd starvation", 32'(max_idle > 24), 32'd0);
    check("rnd progress", 32'(pops > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
